sync_fifo_buf: RTL and testbench

//   Synchronous valid/ready FIFO buffer. Sits directly downstream of data_source in the sync buffer test

---
 rtl/sync_fifo_buf.sv | 74 +++++++
 tb/tb_sync_fifo_buf.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_buf.sv
// sync_fifo_buf: valid/ready FIFO of DEPTH words with one-cycle latency and
// no fall-through. Defining SYNC_FIFO_BUF_STATS_EN adds the xfer_cnt and
// peak_level statistics outputs.
module sync_fifo_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [AW:0]           level
`ifdef SYNC_FIFO_BUF_STATS_EN
    ,
    output logic [15:0]           xfer_cnt,
    output logic [AW:0]           peak_level
`endif
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr;
    logic                  push, pop;

    // Status and handshakes come from registered pointers only, so a pop never frees a slot for a push in the same cycle.
    always_comb begin
        in_ready  = !((wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]));
        out_valid = wr_ptr != rd_ptr;
        level     = wr_ptr - rd_ptr;
        out_data  = mem[rd_ptr[AW-1:0]];
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Pointers advance on accepted transfers and wrap modulo 2*DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
        end
    end

    // Storage is cleared on reset so out_data reads zero until the first write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem <= '{default: '0};
        else if (push)
            mem[wr_ptr[AW-1:0]] <= in_data;
    end

`ifdef SYNC_FIFO_BUF_STATS_EN
    logic [AW:0] level_nxt;

    // Occupancy after this edge, so the peak tracks the level about to be reached.
    always_comb level_nxt = level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    // Pop counter wraps naturally; peak holds the highest occupancy since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt   <= '0;
            peak_level <= '0;
        end else begin
            xfer_cnt   <= xfer_cnt + {15'd0, pop};
            peak_level <= (level_nxt > peak_level) ? level_nxt : peak_level;
        end
    end
`endif
endmodule

// File: tb/tb_sync_fifo_buf.sv
// tb_sync_fifo_buf: scoreboard bench for sync_fifo_buf with directed words.
module tb_sync_fifo_buf;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] level;
`ifdef SYNC_FIFO_BUF_STATS_EN
    logic [15:0] xfer_cnt;
    logic [2:0]  peak_level;
`endif

    int tests = 0;
    int fails = 0;
    int pops = 0;
    logic [7:0] sb[$];
    logic       held_v = 1'b0;
    logic [7:0] held_d = '0;

    sync_fifo_buf #(.DATA_WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level)
`ifdef SYNC_FIFO_BUF_STATS_EN
        , .xfer_cnt(xfer_cnt), .peak_level(peak_level)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a word until accepted (bounded), record it as expected output.
    task automatic push_word(input logic [7:0] d);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(d);
                done = 1'b1;
            end
            tick();
        end
        if (!done) check("push_timeout", 16'd0, 16'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        for (int i = 0; i < 200 && level != 0; i++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
        end
        check("drain_level", 16'(level), 16'd0);
        check("drain_sb_empty", 16'(sb.size()), 16'd0);
        out_ready = 1'b0;
    endtask

    // Monitor: compares each pop against the scoreboard and checks stall stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v && out_valid) check("stall_stable", 16'(out_data), 16'(held_d));
            if (out_valid && out_ready) begin
                pops++;
                if (sb.size() == 0) check("unexpected_pop", 16'(out_data), 16'hFFFF);
                else check("order", 16'(out_data), 16'(sb.pop_front()));
                held_v = 1'b0;
            end else begin
                held_v = out_valid;
                held_d = out_data;
            end
        end
    end

    initial begin
        // Reset values
        #12;
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_in_ready", 16'(in_ready), 16'd1);
        check("rst_level", 16'(level), 16'd0);
        check("rst_out_data", 16'(out_data), 16'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Streaming with constant out_ready
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            push_word(8'(i * 8'h11));
            check("stream_valid", 16'(out_valid), 16'd1);
            check("stream_level", 16'(level), 16'd1);
            check("stream_data", 16'(out_data), 16'(i * 8'h11));
        end
        tick();
        check("stream_end_level", 16'(level), 16'd0);
        check("stream_pops", 16'(pops), 16'd4);

        // Asynchronous reset with three words stored
        out_ready = 1'b0;
        push_word(8'hA1);
        push_word(8'hA2);
        push_word(8'hA3);
        check("pre_rst_level", 16'(level), 16'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_level", 16'(level), 16'd0);
        check("async_rst_valid", 16'(out_valid), 16'd0);
        check("async_rst_ready", 16'(in_ready), 16'd1);
        check("async_rst_data", 16'(out_data), 16'd0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();

        // Fill to full, then hold a fifth word
        pops = 0;
        for (int i = 1; i <= 4; i++) push_word(8'(i * 8'h11));
        check("full_level", 16'(level), 16'd4);
        check("full_in_ready", 16'(in_ready), 16'd0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        tick();
        check("full_hold_level", 16'(level), 16'd4);
        check("full_hold_data", 16'(out_data), 16'h11);

        // Full with valid and ready: pop only, then push and pop together
        out_ready = 1'b1;
        tick();
        check("full_pop_level", 16'(level), 16'd3);
        check("full_pop_ready", 16'(in_ready), 16'd1);
        @(negedge clk);
        if (in_ready) sb.push_back(8'h55);
        tick();
        check("both_level", 16'(level), 16'd3);
        in_valid = 1'b0;
        drain(1'b0);
        check("fill_pops", 16'(pops), 16'd5);
`ifdef SYNC_FIFO_BUF_STATS_EN
        check("peak_level", 16'(peak_level), 16'd4);
        check("xfer_cnt", xfer_cnt, 16'd5);
`endif

        // Wrap: three fill/drain rounds with random stalls
        pops = 0;
        for (int r = 0; r < 3; r++) begin
            out_ready = 1'b0;
            for (int i = 1; i <= 4; i++) push_word(8'(r * 4 + i));
            check("wrap_full", 16'(level), 16'd4);
            drain(1'b1);
        end
        check("wrap_pops", 16'(pops), 16'd12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
